// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared state encoding, mode constants and width defaults for mem_dma
package mem_dma_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    typedef enum logic [1:0] {IDLE, RD, WR, FILL} state_t;
endpackage

// File: rtl/mem_dma_ptr.sv
// mem_dma_ptr: loadable W-bit pointer that steps up (or down when DOWN=1) with wrap
module mem_dma_ptr #(
    parameter int W    = 16,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_step,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    // load wins over step; arithmetic wraps naturally at W bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else if (i_load) r_q <= i_val;
        else if (i_step) r_q <= DOWN ? r_q - 1'b1 : r_q + 1'b1;
    assign o_q = r_q;
endmodule

// File: rtl/mem_dma.sv
// mem_dma: block copy/fill bus initiator for a synchronous single-port memory.
// Optional running byte checksum of written data: define MEM_DMA_CHECKSUM_EN.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W-1:0] Length,
    input  logic [DATA_W-1:0] FillData,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Remaining,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);
    state_t            r_state;
    logic              r_done;
    logic [DATA_W-1:0] r_fill;
    logic              w_accept;
    logic              w_wr;
    logic              w_last;
    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic [ADDR_W-1:0] w_rem;

    assign w_accept = (r_state == IDLE) && Start;
    assign w_wr     = (r_state == WR) || (r_state == FILL);
    assign w_last   = (w_rem == ADDR_W'(1));

    mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_src (
        .clk(CLK), .rst_n(RESET_N), .i_load(w_accept), .i_val(SrcAddr),
        .i_step(r_state == WR), .o_q(w_src)
    );
    mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_dst (
        .clk(CLK), .rst_n(RESET_N), .i_load(w_accept), .i_val(DstAddr),
        .i_step(w_wr), .o_q(w_dst)
    );
    mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b1)) u_rem (
        .clk(CLK), .rst_n(RESET_N), .i_load(w_accept), .i_val(Length),
        .i_step(w_wr), .o_q(w_rem)
    );

    // transfer sequencing; Abort overrides completion so no Done follows an abort
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_fill  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (Start) begin
                    r_fill <= FillData;
                    if (Length == '0) r_done <= 1'b1;
                    else r_state <= (Mode == MODE_FILL) ? FILL : RD;
                end
                RD: r_state <= Abort ? IDLE : WR;
                WR: begin
                    r_state <= (Abort || w_last) ? IDLE : RD;
                    r_done  <= !Abort && w_last;
                end
                FILL: begin
                    r_state <= (Abort || w_last) ? IDLE : FILL;
                    r_done  <= !Abort && w_last;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy       = (r_state != IDLE);
    assign Done       = r_done;
    assign Remaining  = w_rem;
    assign MemWE      = w_wr;
    assign MemAddress = (r_state == RD) ? w_src : (w_wr ? w_dst : '0);
    // copy data flows straight from the memory's held DataOut to its DataIn
    assign MemWData   = (r_state == WR) ? MemRData : ((r_state == FILL) ? r_fill : '0);

`ifdef MEM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    // modular sum of every byte written since the last accepted Start
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) r_sum <= '0;
        else if (w_accept) r_sum <= '0;
        else if (w_wr) r_sum <= r_sum + MemWData;
    assign Checksum = r_sum;
`endif
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized and directed checks of mem_dma against a byte-level copy/fill model
module tb_mem_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0, dst = '0, len = '0;
    logic [7:0]  fill = '0;
    logic        busy, done, we;
    logic [15:0] rem, addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata = '0;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [7:0]  checksum;
`endif
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        sync = 1'b0;
    int          checks = 0;
    int          passes = 0;

    mem_dma dut (
        .CLK(clk), .RESET_N(rst_n), .Start(start), .Mode(mode),
        .SrcAddr(src), .DstAddr(dst), .Length(len), .FillData(fill),
        .Abort(abort), .Busy(busy), .Done(done), .Remaining(rem),
        .MemWE(we), .MemAddress(addr), .MemWData(wdata), .MemRData(rdata)
`ifdef MEM_DMA_CHECKSUM_EN
        , .Checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // synchronous single-port memory; sync copies the model image in while the DMA is idle
    always @(posedge clk) begin
        if (sync) for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
        else if (we) mem[addr] <= wdata;
        else rdata <= mem[addr];
    end

    function automatic int first_diff();
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) return i;
        return -1;
    endfunction

    // model: copy is a strictly ascending byte loop, so overlap and wrap fall out naturally
    task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[16'(d + 16'(i))] = ref_mem[16'(s + 16'(i))];
    endtask

    task automatic ref_fill(input logic [15:0] d, input int n, input logic [7:0] f);
        for (int i = 0; i < n; i++) ref_mem[16'(d + 16'(i))] = f;
    endtask

    task automatic load_mem();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [7:0] f);
        mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int budget, output int t_done, output int n_busy, output int n_we,
                       output logic [127:0] we_hist, output int overlap);
        t_done = -1; n_busy = 0; n_we = 0; we_hist = '0; overlap = 0;
        for (int n = 0; n < budget; n++) begin
            if (done) begin
                if (busy) overlap++;
                t_done = n;
                break;
            end
            if (!busy) break;
            n_busy++;
            if (we) n_we++;
            if (n < 128) we_hist[n] = we;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rem, we, addr, wdata} !== 42'd0)
            $display("FAIL reset_outputs got busy=%b done=%b rem=%h we=%b addr=%h wdata=%h want all 0",
                     busy, done, rem, we, addr, wdata);
        else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
        load_mem();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, we} !== 3'b000) $display("FAIL idle_abort got busy=%b done=%b we=%b want 000", busy, done, we);
        else passes++;
    endtask

    task automatic test_copy();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        ref_mem[16'h0010] = 8'h11; ref_mem[16'h0011] = 8'h22;
        ref_mem[16'h0012] = 8'h33; ref_mem[16'h0013] = 8'h44;
        load_mem();
        launch(1'b0, 16'h0010, 16'h0200, 16'd4, 8'h00);
        run(100, t, nb, nw, h, ov);
        ref_copy(16'h0010, 16'h0200, 4);
        checks++; if (t !== 8) $display("FAIL copy_done_time got %0d want 8", t); else passes++;
        checks++; if (h[7:0] !== 8'b1010_1010) $display("FAIL copy_we_pattern got %b want 10101010", h[7:0]); else passes++;
        checks++; if (nb !== 8) $display("FAIL copy_busy_cycles got %0d want 8", nb); else passes++;
        checks++; if (ov !== 0) $display("FAIL copy_done_with_busy got %0d want 0", ov); else passes++;
        checks++; if (rem !== 16'd0) $display("FAIL copy_remaining got %h want 0000", rem); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL copy_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL copy_done_pulse got %b want 0", done); else passes++;
    endtask

    task automatic test_fill();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        launch(1'b1, 16'h1234, 16'h0300, 16'd3, 8'hA5);
        run(100, t, nb, nw, h, ov);
        ref_fill(16'h0300, 3, 8'hA5);
        checks++; if (t !== 3) $display("FAIL fill_done_time got %0d want 3", t); else passes++;
        checks++; if (nb !== 3 || nw !== 3) $display("FAIL fill_busy_we got busy=%0d we=%0d want 3/3", nb, nw); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL fill_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        ref_mem[16'hFFFF] = 8'h01; ref_mem[16'h0000] = 8'h02; ref_mem[16'h0001] = 8'h03;
        load_mem();
        launch(1'b0, 16'hFFFF, 16'hFFFE, 16'd3, 8'h00);
        run(100, t, nb, nw, h, ov);
        ref_copy(16'hFFFF, 16'hFFFE, 3);
        checks++; if (t !== 6) $display("FAIL wrap_done_time got %0d want 6", t); else passes++;
        checks++;
        if ({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]} !== 24'h010203)
            $display("FAIL wrap_bytes got %h %h %h want 01 02 03", mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
        else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL wrap_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        launch(1'b1, 16'h0000, 16'h0700, 16'd0, 8'h5A);
        checks++; if ({done, busy} !== 2'b10) $display("FAIL len0_done got done=%b busy=%b want 1 0", done, busy); else passes++;
        run(10, t, nb, nw, h, ov);
        checks++; if (nw !== 0 || we !== 1'b0) $display("FAIL len0_we got %0d writes want 0", nw); else passes++;
        @(negedge clk);
        checks++; if ({done, busy, we} !== 3'b000) $display("FAIL len0_after got done=%b busy=%b we=%b want 000", done, busy, we); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL len0_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
    endtask

    task automatic test_ignored_start();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        logic [7:0] f;
        f = 8'($urandom);
        launch(1'b1, 16'h0000, 16'h0500, 16'd6, f);
        @(negedge clk);
        mode = 1'b0; src = 16'h0500; dst = 16'h0600; len = 16'd2; fill = ~f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run(100, t, nb, nw, h, ov);
        ref_fill(16'h0500, 6, f);
        checks++; if (t !== 4) $display("FAIL ignstart_done_time got %0d want 4", t); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL ignstart_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int d;
        logic [7:0] f;
        logic seen_done;
        f = 8'($urandom);
        launch(1'b1, 16'h0000, 16'h0400, 16'h0010, f);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ref_fill(16'h0400, 4, f);
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
        checks++; if (rem !== 16'h000C) $display("FAIL abort_remaining got %h want 000C", rem); else passes++;
        seen_done = done;
        repeat (3) begin @(negedge clk); seen_done |= done; end
        checks++; if (seen_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", seen_done); else passes++;
        checks++; if (rem !== 16'h000C) $display("FAIL abort_rem_hold got %h want 000C", rem); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL abort_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
    endtask

    task automatic test_async_reset();
        int t, nb, nw, ov, d;
        logic [127:0] h;
        launch(1'b0, 16'h0700, 16'h0800, 16'd4, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rem, we, addr, wdata} !== 42'd0)
            $display("FAIL async_reset got busy=%b done=%b rem=%h we=%b addr=%h wdata=%h want all 0",
                     busy, done, rem, we, addr, wdata);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL async_no_write at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        launch(1'b0, 16'h0700, 16'h0800, 16'd4, 8'h00);
        run(100, t, nb, nw, h, ov);
        ref_copy(16'h0700, 16'h0800, 4);
        checks++; if (t !== 8) $display("FAIL async_restart_time got %0d want 8", t); else passes++;
        d = first_diff();
        checks++; if (d !== -1) $display("FAIL async_restart_mem at %h got %h want %h", d, mem[d], ref_mem[d]); else passes++;
        @(negedge clk);
`ifdef MEM_DMA_CHECKSUM_EN
        ref_mem[16'h0900] = 8'h80; ref_mem[16'h0901] = 8'h90;
        load_mem();
        launch(1'b0, 16'h0900, 16'h0A00, 16'd2, 8'h00);
        run(100, t, nb, nw, h, ov);
        ref_copy(16'h0900, 16'h0A00, 2);
        checks++; if (checksum !== 8'h10) $display("FAIL checksum got %h want 10", checksum); else passes++;
        @(negedge clk);
`endif
    endtask

    task automatic test_random();
        int t, d, dur, ab, wrote;
        logic m;
        logic [15:0] s, ds, l;
        logic [7:0] f;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 256; i++) ref_mem[16'h1000 + 16'(i)] = 8'($urandom);
            load_mem();
            m = 1'($urandom_range(0, 1));
            s = 16'h1000 + 16'($urandom_range(0, 63));
            ds = 16'h1000 + 16'($urandom_range(0, 63));
            l = 16'($urandom_range(1, 24));
            f = 8'($urandom);
            dur = m ? int'(l) : 2 * int'(l);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, dur - 1)) : -1;
            wrote = (ab < 0) ? int'(l) : (m ? ab + 1 : (ab + 1) / 2);
            launch(m, s, ds, l, f);
            t = -1;
            for (int n = 0; n < 200; n++) begin
                if (done) begin t = n; break; end
                if (!busy) break;
                if (n == ab) abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            if (m) ref_fill(ds, wrote, f); else ref_copy(s, ds, wrote);
            checks++;
            if (t !== ((ab < 0) ? dur : -1) || rem !== 16'(int'(l) - wrote))
                $display("FAIL rand%0d_timing got done_at=%0d rem=%h want done_at=%0d rem=%h",
                         it, t, rem, (ab < 0) ? dur : -1, 16'(int'(l) - wrote));
            else passes++;
            d = first_diff();
            checks++; if (d !== -1) $display("FAIL rand%0d_mem at %h got %h want %h", it, d, mem[d], ref_mem[d]); else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_wrap();
        test_len_zero();
        test_ignored_start();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Bus initiator for the 64 KiB synchronous single-port memory used by the 6502 core; drives the memory's WE/Address/DataIn side and consumes its registered DataOut.
- Performs block copy (read then write per byte) or block fill (write only) over a programmable address range.
- Sits beside the CPU as an alternate memory master. Arbitration is outside this block: the caller grants the bus for the whole Busy window.

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- Start  in  1  request pulse, sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; captured with Start.
- SrcAddr  in  ADDR_W  copy source base; captured with Start.
- DstAddr  in  ADDR_W  destination base; captured with Start.
- Length  in  ADDR_W  byte count; 0 = no transfer; captured with Start.
- FillData  in  DATA_W  fill byte; captured with Start.
- Abort  in  1  cancel in-progress transfer.
- Busy  out  1  high from the cycle after an accepted Start until return to IDLE.
- Done  out  1  one-cycle pulse on normal completion.
- Remaining  out  ADDR_W  bytes not yet written.
- MemWE  out  1  memory write enable.
- MemAddress  out  ADDR_W  memory address.
- MemWData  out  DATA_W  to memory DataIn.
- MemRData  in  DATA_W  from memory DataOut; valid the cycle after a read address is presented with MemWE=0.

Behaviour:
- Reset (async, RESET_N=0): state IDLE; Busy=0, Done=0, Remaining=0, MemWE=0, MemAddress=0, MemWData=0; captured registers cleared.
- States: IDLE, RD, WR, FILL.
- IDLE with Start=1:
  - Length=0: pulse Done next cycle, stay IDLE, no memory access.
  - Mode=0: go to RD.
  - Mode=1: go to FILL.
  - All inputs are captured. Start outside IDLE is ignored.
- RD: MemWE=0, MemAddress=src pointer. Next state WR.
- WR: MemWE=1, MemAddress=dst pointer, MemWData=MemRData (combinational pass-through; memory holds DataOut while WE=1).
  - On the edge: both pointers +1 (wrap FFFF->0000), Remaining -1.
  - If Remaining was 1: go to IDLE with Done pulsed in the following cycle. Otherwise go to RD.
  - Copy throughput: 2 cycles/byte.
- FILL: MemWE=1, MemAddress=dst pointer, MemWData=FillData latch.
  - Per edge: dst +1, Remaining -1. Exit to IDLE with Done as in WR.
  - Fill throughput: 1 cycle/byte.
- Outside RD/WR/FILL, MemWE=0. MemWE is never high in IDLE.
- Overlap: copy is strictly ascending. With dst in (src, src+Length) the source bytes are overwritten before being read, giving a pattern replication. This is defined behaviour, not an error.
- Abort=1 in any non-IDLE state: next state IDLE, no Done, Busy drops next cycle.
  - An Abort sampled in WR or FILL does not suppress the write on that edge.
  - Remaining holds the residual count.
- Abort in IDLE: no effect.
- Start and Abort simultaneous in IDLE: Start wins.
- Done and Busy are never high together.

Optional Feature:
- Macro MEM_DMA_CHECKSUM_EN.
- Defined:
  - Adds output Checksum[DATA_W-1:0]: 8-bit modular sum of every byte written.
  - Cleared on accepted Start; updated on each write edge; holds after Done or Abort.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package mem_dma_pkg:
  - state enum {IDLE, RD, WR, FILL}
  - mode constants MODE_COPY=1'b0, MODE_FILL=1'b1
  - ADDR_W/DATA_W defaults
- One natural sub-module, mem_dma_ptr: a loadable ADDR_W-bit incrementing pointer with wrap, instantiated for src, dst and a decrementing variant for Remaining.
- The FSM stays in mem_dma.

Test Plan:
- Copy: preload mem[0010..0013]=11,22,33,44; Start Mode=0 Src=0010 Dst=0200 Len=4.
  - Expect mem[0200..0203]=11,22,33,44.
  - Done exactly 8 cycles after the first RD cycle.
  - MemWE alternates 0/1.
- Fill: Start Mode=1 Dst=0300 Len=3 FillData=A5.
  - Expect mem[0300..0302]=A5, mem[0303] unchanged.
  - Busy high 3 cycles, then Done pulse.
- Wrap: copy Src=FFFF Dst=FFFE Len=3, with mem[FFFF]=01, mem[0000]=02, mem[0001]=03.
  - Expect mem[FFFE]=01, mem[FFFF]=02, mem[0000]=03.
  - The read at 0000 occurs after the write at FFFF, so it returns the original 02.
- Length=0 and ignored Start:
  - Start Len=0: Done next cycle, MemWE never 1.
  - Start pulse during an active fill: no effect on the result.
- Abort: fill Dst=0400 Len=10, Abort asserted in the 4th FILL cycle.
  - Expect mem[0400..0403]=fill byte, mem[0404] untouched.
  - Remaining=000C, no Done.
- Async reset mid-copy: drop RESET_N in WR.
  - Outputs zero immediately without waiting for CLK; state IDLE.
  - A new Start after release works.
  - With MEM_DMA_CHECKSUM_EN defined, copy of 80,90: Checksum=10.
